axis_snooper: RTL and testbench

Packet ingress stage for the BPF VM. It accepts one packet at a time from a 32-bit AXI-Stream slave interface and writes it word-by-word into the VM's packet memory through the `snooper_wr_*` port. When the packet is complete it pulses `snooper_done`, which hands the buffer to the filter CPU. It backpressures while the VM has no free buffer, and discards packets too long for packet memory.

---
 rtl/bpf_pkg.sv | 16 +
 rtl/sat_counter.sv | 19 +
 rtl/axis_snooper.sv | 127 ++++++++++++
 tb/tb_axis_snooper.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bpf_pkg.sv
// Shared definitions for the BPF VM packet path: packet memory geometry and
// the ingress snooper state encoding.
package bpf_pkg;

    localparam int PACKET_ADDR_WIDTH = 10;
    localparam int PACKET_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        SNOOP_IDLE  = 3'd0,
        SNOOP_RECV  = 3'd1,
        SNOOP_DROP  = 3'd2,
        SNOOP_DONE  = 3'd3,
        SNOOP_GUARD = 3'd4
    } snoop_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/axis_snooper.sv
// Packet ingress: copies one AXI-Stream packet at a time into packet memory,
// hands it to the filter CPU with snooper_done, and drops oversize packets.
module axis_snooper
    import bpf_pkg::*;
#(
    parameter int ADDR_WIDTH   = PACKET_ADDR_WIDTH,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PACKET_DATA_WIDTH-1:0] s_tdata,
    input  logic                         s_tvalid,
    input  logic                         s_tlast,
    output logic                         s_tready,
    output logic [ADDR_WIDTH-1:0]        snooper_wr_addr,
    output logic [PACKET_DATA_WIDTH-1:0] snooper_wr_data,
    output logic                         snooper_wr_en,
    output logic                         snooper_done,
    input  logic                         ready_for_snooper,
    output logic [31:0]                  pkt_count,
    output logic [31:0]                  drop_count,
    output logic [ADDR_WIDTH:0]          last_len_words
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    // Handshake: a beat transfers on a rising edge where s_tvalid && s_tready;
    // s_tready never looks at s_tvalid.
    snoop_state_t        state;
    logic [ADDR_WIDTH:0] beat_cnt;
    logic [GW-1:0]       guard_cnt;
    logic                ready_by_state;
    logic                accept;
    logic                room;
    logic                pkt_inc;
    logic                drop_inc;

    always_comb begin
        ready_by_state = 1'b0;
        case (state)
            SNOOP_IDLE: ready_by_state = ready_for_snooper;
            SNOOP_RECV: ready_by_state = 1'b1;
            SNOOP_DROP: ready_by_state = 1'b1;
            default:    ready_by_state = 1'b0;
        endcase
    end

    // Gated by reset so nothing is taken while upstream is still held in reset.
    assign s_tready = rst & ready_by_state;
    assign accept   = s_tvalid & s_tready;
    assign room     = ~beat_cnt[ADDR_WIDTH];
    assign pkt_inc  = (state == SNOOP_DONE);
    assign drop_inc = accept & s_tlast &
                      (((state == SNOOP_RECV) & ~room) | (state == SNOOP_DROP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= SNOOP_IDLE;
            beat_cnt        <= '0;
            guard_cnt       <= '0;
            snooper_wr_en   <= 1'b0;
            snooper_wr_addr <= '0;
            snooper_wr_data <= '0;
            snooper_done    <= 1'b0;
            last_len_words  <= '0;
        end else begin
            snooper_wr_en <= 1'b0;
            snooper_done  <= 1'b0;
            case (state)
                SNOOP_IDLE: begin
                    if (accept) begin
                        snooper_wr_en   <= 1'b1;
                        snooper_wr_addr <= '0;
                        snooper_wr_data <= s_tdata;
                        beat_cnt        <= (ADDR_WIDTH + 1)'(1);
                        state           <= s_tlast ? SNOOP_DONE : SNOOP_RECV;
                    end
                end
                SNOOP_RECV: begin
                    if (accept) begin
                        if (room) begin
                            snooper_wr_en   <= 1'b1;
                            snooper_wr_addr <= beat_cnt[ADDR_WIDTH-1:0];
                            snooper_wr_data <= s_tdata;
                            beat_cnt        <= beat_cnt + 1'b1;
                            if (s_tlast) state <= SNOOP_DONE;
                        end else begin
                            // Memory already full: the rest of the packet is discarded.
                            state <= s_tlast ? SNOOP_IDLE : SNOOP_DROP;
                        end
                    end
                end
                SNOOP_DROP: begin
                    if (accept && s_tlast) state <= SNOOP_IDLE;
                end
                SNOOP_DONE: begin
                    snooper_done   <= 1'b1;
                    last_len_words <= beat_cnt;
                    guard_cnt      <= '0;
                    state          <= (GUARD_CYCLES == 0) ? SNOOP_IDLE : SNOOP_GUARD;
                end
                SNOOP_GUARD: begin
                    // Give the VM time to drop ready_for_snooper after its buffer swap.
                    if (guard_cnt == GUARD_LAST) state <= SNOOP_IDLE;
                    else guard_cnt <= guard_cnt + 1'b1;
                end
                default: state <= SNOOP_IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(32)) u_pkt_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (pkt_inc),
        .count (pkt_count)
    );

    sat_counter #(.WIDTH(32)) u_drop_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (drop_count)
    );

endmodule

// File: tb/tb_axis_snooper.sv
// Bench for axis_snooper: directed steps with random data and gaps, checked
// against a packet-level model of the expected memory writes and counters.
module tb_axis_snooper;
    import bpf_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int G     = 2;
    localparam int EW    = 1 + AW + 32;

    typedef logic [31:0] word_q_t[$];

    logic          clk;
    logic          rst;
    logic [31:0]   s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [AW-1:0] snooper_wr_addr;
    logic [31:0]   snooper_wr_data;
    logic          snooper_wr_en;
    logic          snooper_done;
    logic          ready_for_snooper;
    logic [31:0]   pkt_count;
    logic [31:0]   drop_count;
    logic [AW:0]   last_len_words;

    axis_snooper #(.ADDR_WIDTH(AW), .GUARD_CYCLES(G)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_tdata           (s_tdata),
        .s_tvalid          (s_tvalid),
        .s_tlast           (s_tlast),
        .s_tready          (s_tready),
        .snooper_wr_addr   (snooper_wr_addr),
        .snooper_wr_data   (snooper_wr_data),
        .snooper_wr_en     (snooper_wr_en),
        .snooper_done      (snooper_done),
        .ready_for_snooper (ready_for_snooper),
        .pkt_count         (pkt_count),
        .drop_count        (drop_count),
        .last_len_words    (last_len_words)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // scoreboard: memory writes in order, a done marker after each delivered packet
    logic [EW-1:0] exp_q[$];
    longint        exp_pkt  = 0;
    longint        exp_drop = 0;
    longint        exp_last = 0;
    logic          prev_wr  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [EW-1:0] obs;
        if (snooper_wr_en) begin
            obs = {1'b0, snooper_wr_addr, snooper_wr_data};
            check("pending_on_write", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("write", obs, exp_q.pop_front());
        end
        if (snooper_done) begin
            obs = {1'b1, {(EW - 1){1'b0}}};
            check("pending_on_done", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("done", obs, exp_q.pop_front());
            check("done_follows_write", prev_wr, 1'b1);
        end
        prev_wr = snooper_wr_en;
    end

    // reference model: a packet of len words lands at 0..len-1 if it fits,
    // otherwise the first DEPTH words are written and the packet is dropped
    task automatic expect_packet(input word_q_t beats);
        int len;
        int n;
        len = beats.size();
        n   = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, AW'(i), beats[i]});
        if (len <= DEPTH) begin
            exp_q.push_back({1'b1, {(EW - 1){1'b0}}});
            if (exp_pkt < 64'hFFFF_FFFF) exp_pkt++;
            exp_last = len;
        end else begin
            if (exp_drop < 64'hFFFF_FFFF) exp_drop++;
        end
    endtask

    function automatic word_q_t make_pkt(input int len, input logic [31:0] first, input logic [31:0] last);
        word_q_t q;
        for (int i = 0; i < len; i++) q.push_back($urandom);
        q[0] = first;
        if (len > 1) q[len-1] = last;
        return q;
    endfunction

    // driver: called at a negedge, returns at the negedge after the beat was taken
    task automatic send_beat(input logic [31:0] data, input logic last);
        int waited;
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tlast  = last;
        #1;
        waited = 0;
        while (!s_tready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!s_tready) check("tready_timeout", s_tready, 1'b1);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_packet(input word_q_t beats, input int max_gap);
        expect_packet(beats);
        for (int i = 0; i < beats.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_beat(beats[i], i == beats.size() - 1);
        end
    endtask

    task automatic finish_packet(input string tag);
        repeat (G + 4) @(negedge clk);
        check({tag, "_pkt_count"}, pkt_count, exp_pkt);
        check({tag, "_drop_count"}, drop_count, exp_drop);
        check({tag, "_last_len"}, last_len_words, exp_last);
        check({tag, "_all_seen"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        word_q_t p;

        // reset with a valid beat pending and the VM ready
        rst = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = $urandom;
        s_tlast = 1'b0;
        ready_for_snooper = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tready", s_tready, 1'b0);
        check("rst_wr_en", snooper_wr_en, 1'b0);
        check("rst_done", snooper_done, 1'b0);
        check("rst_wr_addr", snooper_wr_addr, 0);
        check("rst_wr_data", snooper_wr_data, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_last_len", last_len_words, 0);
        check("rst_state", dut.state, SNOOP_IDLE);
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // 11-beat packet
        send_packet(make_pkt(11, 32'hDEADBEEF, 32'hFFFFFFFF), 0);
        finish_packet("p11");

        // VM not ready: valid held for 30 cycles must not be taken
        p = make_pkt(3, $urandom, $urandom);
        expect_packet(p);
        ready_for_snooper = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = p[0];
        s_tlast = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("stall_tready", s_tready, 1'b0);
        end
        ready_for_snooper = 1'b1;
        send_beat(p[0], 1'b0);
        check("stall_first_wr_en", snooper_wr_en, 1'b1);
        check("stall_first_wr_addr", snooper_wr_addr, 0);
        send_beat(p[1], 1'b0);
        send_beat(p[2], 1'b1);
        finish_packet("stall");

        // 14 beats with random gaps; ready falls mid-packet without effect
        p = make_pkt(14, 32'h70b31760, 32'h0000FFFF);
        expect_packet(p);
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i == 5) ready_for_snooper = 1'b0;
            send_beat(p[i], i == 13);
        end
        ready_for_snooper = 1'b1;
        finish_packet("p14_gaps");

        // single-beat packet
        send_packet(make_pkt(1, $urandom, 32'h0), 1);
        finish_packet("p1");

        // exactly fills memory
        send_packet(make_pkt(DEPTH, $urandom, $urandom), 1);
        finish_packet("full");

        // one beat too many: dropped, then a normal packet follows
        send_packet(make_pkt(DEPTH + 1, $urandom, $urandom), 1);
        finish_packet("oversize");
        check("oversize_state_idle", dut.state, SNOOP_IDLE);
        send_packet(make_pkt(3, $urandom, $urandom), 0);
        finish_packet("after_drop");

        // random lengths around the memory boundary
        for (int k = 0; k < 6; k++) begin
            send_packet(make_pkt($urandom_range(1, DEPTH + 4), $urandom, $urandom), 2);
            finish_packet("random");
        end

        // reset after beat 5 of 10
        p = make_pkt(10, $urandom, $urandom);
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, AW'(i), p[i]});
        for (int i = 0; i < 5; i++) send_beat(p[i], 1'b0);
        #2;
        s_tvalid = 1'b1;
        s_tdata = p[5];
        rst = 1'b0;
        #1;
        exp_pkt = 0;
        exp_drop = 0;
        exp_last = 0;
        check("midrst_wr_en", snooper_wr_en, 1'b0);
        check("midrst_wr_addr", snooper_wr_addr, 0);
        check("midrst_wr_data", snooper_wr_data, 0);
        check("midrst_tready", s_tready, 1'b0);
        check("midrst_done", snooper_done, 1'b0);
        check("midrst_pkt_count", pkt_count, exp_pkt);
        check("midrst_last_len", last_len_words, exp_last);
        check("midrst_all_seen", exp_q.size(), 0);
        @(negedge clk);
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        send_packet(make_pkt(2, $urandom, $urandom), 0);
        finish_packet("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
